alu_arbiter: RTL



---
 rtl/alu_arbiter_if.sv | 41 ++++
 rtl/alu_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
// Requester-side bus of the two-port ALU arbiter. Every signal is a
// two-entry packed array indexed by requester (0/1), except the result
// data and carry, which go to both requesters.
//
//   r_cmd_valid  [1:0]          command valid, per requester
//   r_cmd_ready  [1:0]          command accepted, per requester
//   r_ops        [1:0][31:0]    operands {x0,x1,y0,y1}, x0 in MSBs
//   r_ctrl       [1:0][CTRL_W]  ALU control word
//   r_lock       [1:0]          keep the grant after this command
//   r_res_valid  [1:0]          result valid, only the owner's bit is set
//   r_res_ready  [1:0]          requester ready for its result
//   r_res        [17:0]         result data, sent to both requesters
//   r_carry                     result carry, sent to both requesters
//
// master: the requesters. slave: the arbiter.
// ---------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int CTRL_W = 16
);
    logic [1:0]             r_cmd_valid;
    logic [1:0]             r_cmd_ready;
    logic [1:0][31:0]       r_ops;
    logic [1:0][CTRL_W-1:0] r_ctrl;
    logic [1:0]             r_lock;
    logic [1:0]             r_res_valid;
    logic [1:0]             r_res_ready;
    logic [17:0]            r_res;
    logic                   r_carry;

    modport master (
        output r_cmd_valid, r_ops, r_ctrl, r_lock, r_res_ready,
        input  r_cmd_ready, r_res_valid, r_res, r_carry
    );

    modport slave (
        input  r_cmd_valid, r_ops, r_ctrl, r_lock, r_res_ready,
        output r_cmd_ready, r_res_valid, r_res, r_carry
    );
endinterface

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Lets two command sources share one alu_stage. Each cycle one requester is
// granted, and its operands and ctrl are forwarded to the ALU command
// handshake with no added latency. The grant is round-robin. It is frozen
// while a presented command waits for the ALU (HOLD). A requester may keep
// the grant for a bounded burst of dependent commands (LOCK). The requester
// whose command fired last owns the single in-flight result, and the result
// handshake is steered back to that requester.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   req             requester bus (alu_arbiter_if.slave)
//   alu_x0..alu_y1  8-bit operands to the ALU
//   alu_ctrl        ctrl word to the ALU
//   alu_cmd_valid   command valid to the ALU
//   alu_cmd_ready   ALU accepts a command
//   alu_res_valid   ALU result valid
//   alu_res_ready   result accepted by the owning requester
//   alu_res         ALU result data
//   alu_carry       ALU carry
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int CTRL_W    = 16,
    parameter int MAX_BURST = 4     // 1..15
) (
    input  logic              clk,
    input  logic              rst,
    alu_arbiter_if.slave      req,
    output logic [7:0]        alu_x0,
    output logic [7:0]        alu_x1,
    output logic [7:0]        alu_y0,
    output logic [7:0]        alu_y1,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              alu_cmd_valid,
    input  logic              alu_cmd_ready,
    input  logic              alu_res_valid,
    output logic              alu_res_ready,
    input  logic [17:0]       alu_res,
    input  logic              alu_carry
);

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_HOLD = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    state_t     state_reg;
    logic       last_reg;       // requester that fired most recently
    logic       owner_reg;      // requester owning the in-flight result
    logic       hold_g_reg;     // grant frozen while in HOLD
    logic [3:0] burst_cnt_reg;  // commands issued in the current lock

    logic        g;
    logic        cmd_valid;
    logic        fire;
    logic        lock_g;
    logic [31:0] ops_g;

    // Grant select. In ARB the requester that did not go last wins if it is
    // asking. Otherwise the grant falls back to the one that did go last.
    always_comb begin
        g = ~last_reg;
        unique case (state_reg)
            ST_ARB:  g = (req.r_cmd_valid[~last_reg] || !req.r_cmd_valid[last_reg])
                         ? ~last_reg : last_reg;
            ST_HOLD: g = hold_g_reg;
            ST_LOCK: g = last_reg;
            default: g = ~last_reg;
        endcase
    end

    // Zero-latency command path, forced quiet while reset is asserted.
    assign cmd_valid = ~rst & req.r_cmd_valid[g];
    assign fire      = cmd_valid & alu_cmd_ready;
    assign lock_g    = req.r_lock[g];
    assign ops_g     = rst ? 32'd0 : req.r_ops[g];

    assign alu_cmd_valid = cmd_valid;
    assign alu_x0        = ops_g[31:24];
    assign alu_x1        = ops_g[23:16];
    assign alu_y0        = ops_g[15:8];
    assign alu_y1        = ops_g[7:0];
    assign alu_ctrl      = rst ? '0 : req.r_ctrl[g];

    // Result path. The previous owner keeps routing until the clock edge,
    // so a drain and a new fire in the same cycle go to the right requesters.
    assign alu_res_ready = ~rst & req.r_res_ready[owner_reg];
    assign req.r_res     = alu_res;
    assign req.r_carry   = alu_carry;

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign req.r_cmd_ready[gi] = ~rst & (g == 1'(gi)) & alu_cmd_ready;
        assign req.r_res_valid[gi] = ~rst & (owner_reg == 1'(gi)) & alu_res_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_ARB;
            last_reg      <= 1'b1;
            owner_reg     <= 1'b0;
            hold_g_reg    <= 1'b0;
            burst_cnt_reg <= 4'd0;
        end else begin
            if (fire) begin
                owner_reg <= g;
            end

            unique case (state_reg)
                ST_ARB, ST_HOLD: begin
                    if (fire) begin
                        last_reg <= g;
                        if (lock_g && (MAX_BURST > 1)) begin
                            burst_cnt_reg <= 4'd1;
                            state_reg     <= ST_LOCK;
                        end else begin
                            state_reg <= ST_ARB;
                        end
                    end else if (cmd_valid) begin
                        hold_g_reg <= g;
                        state_reg  <= ST_HOLD;
                    end else begin
                        // Nothing presented, or a held requester withdrew.
                        state_reg <= ST_ARB;
                    end
                end

                ST_LOCK: begin
                    // last_reg stays on the lock owner. The other requester
                    // therefore has priority once the lock ends.
                    if (!req.r_cmd_valid[last_reg]) begin
                        state_reg <= ST_ARB;
                    end else if (fire) begin
                        if (!lock_g || (burst_cnt_reg + 4'd1 == BURST_MAX)) begin
                            state_reg <= ST_ARB;
                        end else begin
                            burst_cnt_reg <= burst_cnt_reg + 4'd1;
                        end
                    end
                end

                default: state_reg <= ST_ARB;
            endcase
        end
    end

endmodule
